// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the multicycle control unit. A single
//   CHUNK_W-wide array holds the instruction and data regions. Instruction
//   reads return one chunk. Data reads and writes move one WORD_W word as
//   four chunk beats, most significant chunk first. WAIT_CYC wait cycles
//   come before each beat.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   memread        read request, sampled in IDLE
//   memwrite       write request, sampled in IDLE
//   data_not_instr 1 = data region (4 beats), 0 = instruction region (1 beat)
//   addr           chunk address of the request (first chunk for data)
//   wdata          write word, captured at acceptance
//   rdata          read result; an instruction chunk is zero-extended
//   ready          one-cycle completion pulse
//   busy           high from acceptance through the ready cycle
//   err            one-cycle pulse on an illegal request
module mem_responder #(
  parameter int CHUNK_W   = 7,
  parameter int WORD_W    = 28,
  parameter int ADDR_W    = 10,
  parameter int DATA_BASE = 512,
  parameter int WAIT_CYC  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              data_not_instr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(DATA_BASE);
  localparam logic [2:0]        WLAST = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_DONE} state_t;

  logic [CHUNK_W-1:0] mem [DEPTH];

  state_t             state;
  logic [ADDR_W-1:0]  a_addr;
  logic [WORD_W-1:0]  a_wdata;
  logic               a_write;
  logic               a_data;
  logic [1:0]         beat;
  logic [2:0]         wcnt;

  logic [ADDR_W-1:0]  eff_addr;
  logic [CHUNK_W-1:0] wr_chunk;
  logic [CHUNK_W-1:0] rd_chunk;
  logic               last_beat;
  logic               req_legal;
  logic               req_illegal;

  always_comb begin
    // The sum is truncated to ADDR_W bits, so a wrap past the top of the
    // array is silent.
    eff_addr    = a_addr + (a_data ? BASE : '0) + ADDR_W'(beat);
    wr_chunk    = a_wdata[WORD_W-1-CHUNK_W*int'(beat) -: CHUNK_W];
    rd_chunk    = mem[eff_addr];
    last_beat   = !a_data || (beat == 2'd3);
    req_illegal = (memread && memwrite) || (memwrite && !data_not_instr);
    req_legal   = (memread || memwrite) && !req_illegal;
  end

  // The array is not reset. Reset moves the FSM out of S_BEAT
  // asynchronously, which blocks any further writes of an aborted
  // transfer.
  always_ff @(posedge clk) begin
    if (state == S_BEAT && a_write)
      mem[eff_addr] <= wr_chunk;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      rdata   <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      beat    <= '0;
      wcnt    <= '0;
      a_addr  <= '0;
      a_wdata <= '0;
      a_write <= 1'b0;
      a_data  <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_illegal) begin
            err <= 1'b1;
          end else if (req_legal) begin
            a_addr  <= addr;
            a_wdata <= wdata;
            a_write <= memwrite;
            a_data  <= data_not_instr;
            beat    <= '0;
            wcnt    <= '0;
            busy    <= 1'b1;
            state   <= (WAIT_CYC > 0) ? S_WAIT : S_BEAT;
          end
        end
        S_WAIT: begin
          if (wcnt == WLAST) begin
            wcnt  <= '0;
            state <= S_BEAT;
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        S_BEAT: begin
          if (!a_write) begin
            if (a_data)
              rdata[WORD_W-1-CHUNK_W*int'(beat) -: CHUNK_W] <= rd_chunk;
            else
              rdata <= WORD_W'(rd_chunk);
          end
          if (last_beat) begin
            // ready is registered so that it is high during S_DONE.
            ready <= 1'b1;
            state <= S_DONE;
          end else begin
            beat  <= beat + 2'd1;
            state <= (WAIT_CYC > 0) ? S_WAIT : S_BEAT;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int CW = 7;
  localparam int WW = 28;
  localparam int AW = 10;
  localparam int DB = 512;
  localparam int WC = 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          memread = 1'b0;
  logic          memwrite = 1'b0;
  logic          data_not_instr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [WW-1:0] wdata = '0;
  logic [WW-1:0] rdata;
  logic          ready;
  logic          busy;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_responder #(
    .CHUNK_W(CW), .WORD_W(WW), .ADDR_W(AW), .DATA_BASE(DB), .WAIT_CYC(WC)
  ) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .data_not_instr(data_not_instr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Transaction-level reference. A transfer accepted at edge k=0 performs
  // beat b at edge (b+1)*(WC+1). ready is high after edge L = nbeats*(WC+1),
  // and the responder is back in IDLE after edge L+1.
  logic [CW-1:0] mm [DEPTH];
  logic [WW-1:0] e_rdata = '0;
  bit            e_ready = 0, e_busy = 0, e_err = 0;
  bit            m_act = 0, m_wr = 0, m_dni = 0;
  int            m_k = 0, m_len = 0;
  logic [AW-1:0] m_a = '0;
  logic [WW-1:0] m_wd = '0;

  always @(posedge clk or negedge reset) begin
    int b, ea;
    if (!reset) begin
      m_act = 0; e_rdata = '0; e_ready = 0; e_busy = 0; e_err = 0;
    end else begin
      e_err = 0;
      e_ready = 0;
      if (m_act) begin
        m_k++;
        if (m_k > m_len) begin
          m_act = 0;
        end else if (m_k % (WC + 1) == 0) begin
          b  = m_k / (WC + 1) - 1;
          ea = ((m_dni ? DB : 0) + int'(m_a) + b) % DEPTH;
          if (m_wr) mm[ea] = m_wd[WW-1-CW*b -: CW];
          else if (m_dni) e_rdata[WW-1-CW*b -: CW] = mm[ea];
          else e_rdata = WW'(mm[ea]);
        end
        if (m_act && m_k == m_len) e_ready = 1;
      end else begin
        if ((memread && memwrite) || (memwrite && !data_not_instr)) begin
          e_err = 1;
        end else if (memread || memwrite) begin
          m_act = 1; m_k = 0;
          m_len = (data_not_instr ? 4 : 1) * (WC + 1);
          m_wr = memwrite; m_dni = data_not_instr; m_a = addr; m_wd = wdata;
        end
      end
      e_busy = m_act;
    end
  end

  always @(negedge clk) begin
    chk("rdata", 32'(rdata), 32'(e_rdata));
    chk("ready", 32'(ready), 32'(e_ready));
    chk("busy",  32'(busy),  32'(e_busy));
    chk("err",   32'(err),   32'(e_err));
  end

  // Issue one request and measure the edges from acceptance to ready.
  // The responder must be idle or in DONE when this is called.
  task automatic xact(input logic rd, input logic wr, input logic dni,
                      input logic [AW-1:0] a, input logic [WW-1:0] wd,
                      output int lat, output logic [WW-1:0] rd_out);
    @(posedge clk); #1;
    memread = rd; memwrite = wr; data_not_instr = dni; addr = a; wdata = wd;
    @(posedge clk); #1;
    memread = 0; memwrite = 0;
    lat = -1;
    rd_out = '0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (ready) begin
        lat = e;
        rd_out = rdata;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic bad_req(input logic wr_only, output int n_err, output int n_rdy);
    @(posedge clk); #1;
    memread = !wr_only; memwrite = 1; data_not_instr = !wr_only; addr = '0; wdata = '1;
    @(posedge clk); #1;
    memread = 0; memwrite = 0;
    n_err = 0;
    n_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_err += int'(err);
      n_rdy += int'(ready);
    end
  endtask

  initial begin
    int lat, ne, nr;
    logic [WW-1:0] r, w;
    logic [CW-1:0] c [4];
    bit rdy6 [8];
    bit bsy6 [8];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", 32'(rdata), 32'h0);
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_busy",  32'(busy),  32'h0);
    chk("reset_err",   32'(err),   32'h0);
    reset = 1;

    // Fill the whole array through the data region.
    for (int i = 0; i < DEPTH / 4; i++)
      xact(0, 1, 1, AW'(4 * i), WW'($urandom), lat, r);

    // Instruction region 0..3 through data address 512 (wraps to array 0).
    w = {7'h11, 7'h22, 7'h33, 7'h44};
    xact(0, 1, 1, AW'(512), w, lat, r);
    chk("preload_lat", 32'(lat), 32'd8);
    c = '{7'h11, 7'h22, 7'h33, 7'h44};
    for (int i = 0; i < 4; i++) begin
      xact(1, 0, 0, AW'(i), '0, lat, r);
      chk("instr_lat", 32'(lat), 32'd2);
      chk("instr_rdata", 32'(r), 32'(c[i]));
    end

    xact(0, 1, 1, AW'(5), 28'h0ABCDEF, lat, r);
    chk("dwr_lat", 32'(lat), 32'd8);
    xact(1, 0, 1, AW'(5), '0, lat, r);
    chk("drd_lat", 32'(lat), 32'd8);
    chk("drd_rdata", 32'(r), 32'h0ABCDEF);
    xact(1, 0, 0, AW'(517), '0, lat, r);
    chk("array517", 32'(r), 32'h05);

    // Wrap: data addr 1022 covers array 510, 511, 512, 513.
    w = {7'h01, 7'h02, 7'h03, 7'h04};
    xact(0, 1, 1, AW'(1022), w, lat, r);
    for (int i = 0; i < 4; i++) begin
      xact(1, 0, 0, AW'(510 + i), '0, lat, r);
      chk("wrap_chunk", 32'(r), 32'(i + 1));
    end
    xact(1, 0, 1, AW'(1022), '0, lat, r);
    chk("wrap_word", 32'(r), 32'(w));

    bad_req(0, ne, nr);
    chk("rw_err_cycles", 32'(ne), 32'd1);
    chk("rw_ready", 32'(nr), 32'd0);
    bad_req(1, ne, nr);
    chk("iwr_err_cycles", 32'(ne), 32'd1);
    chk("iwr_ready", 32'(nr), 32'd0);
    xact(1, 0, 0, AW'(0), '0, lat, r);
    chk("iwr_unchanged", 32'(r), 32'h11);

    // Reset after beat 1 of a data write to array 0..3.
    @(posedge clk); #1;
    memwrite = 1; data_not_instr = 1; addr = AW'(512); wdata = {7'h55, 7'h66, 7'h77, 7'h08};
    @(posedge clk); #1;
    memwrite = 0;
    repeat (4) @(posedge clk);
    #2 reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_ready", 32'(ready), 32'h0);
      chk("abort_busy",  32'(busy),  32'h0);
      chk("abort_rdata", 32'(rdata), 32'h0);
    end
    reset = 1;
    c = '{7'h55, 7'h66, 7'h33, 7'h44};
    for (int i = 0; i < 4; i++) begin
      xact(1, 0, 0, AW'(i), '0, lat, r);
      chk("abort_chunk", 32'(r), 32'(c[i]));
    end

    // memread held high across DONE.
    @(posedge clk); #1;
    memread = 1; data_not_instr = 0; addr = '0;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rdy6[i] = ready;
      bsy6[i] = busy;
    end
    memread = 0;
    chk("hold_ready1", 32'(rdy6[2]), 32'h1);
    chk("hold_gap", 32'(bsy6[3]), 32'h0);
    chk("hold_reaccept", 32'(bsy6[4]), 32'h1);
    chk("hold_ready2", 32'(rdy6[6]), 32'h1);
    repeat (4) @(posedge clk);

    // Random traffic, including requests while busy and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      int sel;
      @(posedge clk); #1;
      sel = $urandom_range(0, 9);
      memread  = (sel <= 3) || (sel == 7);
      memwrite = (sel >= 4 && sel <= 7);
      data_not_instr = ($urandom_range(0, 3) != 0);
      addr  = AW'($urandom);
      wdata = WW'($urandom);
      if ($urandom_range(0, 299) == 0) reset = 0;
      else reset = 1;
    end
    @(posedge clk); #1;
    reset = 1; memread = 0; memwrite = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
